// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grants held until release.
// Optional forced release after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [3:0] gnt_q;
    logic [1:0] gnt_id_q;
    logic       busy_q;
    logic       timeout_q;
`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_q;
`endif

    logic [3:0] rot_s;
    logic [1:0] off_s;
    logic [1:0] pick_s;
    logic       pick_vld_s;

    if ((MAX_HOLD < 2) || (MAX_HOLD > 255) || ((64'd1 << CNT_W) <= 64'(MAX_HOLD))) begin : g_param_check
        $error("rr_arbiter4: MAX_HOLD must be 2..255 and fit in CNT_W bits");
    end

    // Rotate requests so the pointer position is bit 0, then take the lowest set bit.
    always_comb begin
        rot_s = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            rot_s[k] = req[2'(ptr_q + 2'(k))];
        end
        if (rot_s[0]) begin
            off_s = 2'd0;
        end else if (rot_s[1]) begin
            off_s = 2'd1;
        end else if (rot_s[2]) begin
            off_s = 2'd2;
        end else begin
            off_s = 2'd3;
        end
        pick_s     = ptr_q + off_s;
        pick_vld_s = |req;
    end

    // Arbitration FSM; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'b00;
            gnt_q     <= 4'b0000;
            gnt_id_q  <= 2'b00;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
`endif
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        state_q  <= ST_GRANT;
                        gnt_q    <= 4'b0001 << pick_s;
                        gnt_id_q <= pick_s;
                        busy_q   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                        hold_q   <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    // A req drop wins over a simultaneous timeout: plain release, no pulse.
                    if (!req[gnt_id_q]) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= 4'b0000;
                        busy_q  <= 1'b0;
                        ptr_q   <= gnt_id_q + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_q == CNT_W'(MAX_HOLD - 1)) begin
                        state_q   <= ST_IDLE;
                        gnt_q     <= 4'b0000;
                        busy_q    <= 1'b0;
                        ptr_q     <= gnt_id_q + 2'd1;
                        timeout_q <= 1'b1;
                    end else begin
                        hold_q <= hold_q + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign gnt_id  = gnt_id_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios plus randomized traffic
// against a behavioural round-robin model (timeout checks follow ARB_TIMEOUT_EN).
module tb_rr_arbiter4;

    localparam int MAX_HOLD = 8;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // behavioural model state
    int m_ptr;
    int m_owner;
    bit m_busy;
    bit m_timeout;
    int m_hold;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_busy = 1'b0; m_timeout = 1'b0; m_hold = 0;
    endtask

    // Next state of the model after one clock edge with request vector r.
    task automatic model_edge(input logic [3:0] r);
        bit found;
        m_timeout = 1'b0;
        if (m_busy) begin
            if (!r[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % 4;
            end else begin
`ifdef ARB_TIMEOUT_EN
                if (m_hold == MAX_HOLD - 1) begin
                    m_busy    = 1'b0;
                    m_ptr     = (m_owner + 1) % 4;
                    m_timeout = 1'b1;
                end else begin
                    m_hold = m_hold + 1;
                end
`endif
            end
        end else if (r != 4'b0000) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && r[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                    found   = 1'b1;
                end
            end
            m_busy = 1'b1;
            m_hold = 0;
        end
    endtask

    task automatic tick(input logic [3:0] r);
        req = r;
        model_edge(r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 4'b0000;
        model_reset();
        #11;
        total_cnt++;
        if ({gnt, gnt_id, busy, timeout} !== 8'b0000_00_0_0) $display("FAIL reset_state: got gnt=%b id=%0d busy=%b to=%b, want 0000/0/0/0", gnt, gnt_id, busy, timeout);
        else pass_cnt++;
        #1 reset = 1'b0;
        tick(4'b0100);
        total_cnt++;
        if (gnt !== 4'b0100) $display("FAIL reset_owner2: got gnt=%b want 0100", gnt);
        else pass_cnt++;
        #3 reset = 1'b1;
        model_reset();
        #1;
        total_cnt++;
        if ({gnt, gnt_id, busy, timeout} !== 8'b0000_00_0_0) $display("FAIL reset_midgrant: got gnt=%b id=%0d busy=%b to=%b, want 0000/0/0/0", gnt, gnt_id, busy, timeout);
        else pass_cnt++;
        #2 reset = 1'b0;
        tick(4'b0100);
        total_cnt++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2) $display("FAIL reset_regrant: got gnt=%b id=%0d want 0100/2", gnt, gnt_id);
        else pass_cnt++;
        tick(4'b0000);
    endtask

    task automatic test_single();
        reset = 1'b1;
        model_reset();
        #3 reset = 1'b0;
        tick(4'b0010);
        total_cnt++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1 || busy !== 1'b1) $display("FAIL single_grant: got gnt=%b id=%0d busy=%b want 0010/1/1", gnt, gnt_id, busy);
        else pass_cnt++;
        tick(4'b0000);
        total_cnt++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd1) $display("FAIL single_release: got gnt=%b id=%0d busy=%b want 0000/1/0", gnt, gnt_id, busy);
        else pass_cnt++;
        // pointer is now 2: among 0,1,3 the winner must be 3
        tick(4'b1011);
        total_cnt++;
        if (gnt !== 4'b1000) $display("FAIL single_ptr2: got gnt=%b want 1000", gnt);
        else pass_cnt++;
        tick(4'b0000);
    endtask

    task automatic test_rotation();
        for (int k = 0; k < 4; k++) begin
            logic [3:0] one;
            one = 4'b0001 << k;
            tick(4'b1111);
            total_cnt++;
            if (gnt !== one) $display("FAIL rotation_grant%0d: got gnt=%b want %b", k, gnt, one);
            else pass_cnt++;
            tick(4'b1111 & ~one);
            total_cnt++;
            if (gnt !== 4'b0000) $display("FAIL rotation_gap%0d: got gnt=%b want 0000", k, gnt);
            else pass_cnt++;
        end
        tick(4'b1111);
        total_cnt++;
        if (gnt !== 4'b0001) $display("FAIL rotation_wrap: got gnt=%b want 0001", gnt);
        else pass_cnt++;
        tick(4'b0000);
    endtask

    task automatic test_wrap_no_preempt();
        tick(4'b0100);
        tick(4'b0000);
        tick(4'b1001);
        total_cnt++;
        if (gnt !== 4'b1000) $display("FAIL wrap_grant3: got gnt=%b want 1000", gnt);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            tick(4'b1011);
            total_cnt++;
            if (gnt !== 4'b1000 || gnt_id !== 2'd3) $display("FAIL no_preempt%0d: got gnt=%b id=%0d want 1000/3", k, gnt, gnt_id);
            else pass_cnt++;
        end
        tick(4'b0011);
        total_cnt++;
        if (gnt !== 4'b0000) $display("FAIL wrap_release: got gnt=%b want 0000", gnt);
        else pass_cnt++;
        tick(4'b0011);
        total_cnt++;
        if (gnt !== 4'b0001) $display("FAIL wrap_next0: got gnt=%b want 0001", gnt);
        else pass_cnt++;
        tick(4'b0000);
    endtask

    task automatic test_idle();
        tick(4'b0100);
        tick(4'b0000);
        for (int k = 0; k < 10; k++) begin
            tick(4'b0000);
            total_cnt++;
            if (gnt !== 4'b0000 || busy !== 1'b0 || gnt_id !== 2'd2 || timeout !== 1'b0) $display("FAIL idle%0d: got gnt=%b busy=%b id=%0d to=%b want 0000/0/2/0", k, gnt, busy, gnt_id, timeout);
            else pass_cnt++;
        end
    endtask

    task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < MAX_HOLD; k++) begin
            tick(4'b0001);
            total_cnt++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) $display("FAIL timeout_hold%0d: got gnt=%b to=%b want 0001/0", k, gnt, timeout);
            else pass_cnt++;
        end
        tick(4'b0001);
        total_cnt++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b1) $display("FAIL timeout_release: got gnt=%b busy=%b to=%b want 0000/0/1", gnt, busy, timeout);
        else pass_cnt++;
        tick(4'b0001);
        total_cnt++;
        if (gnt !== 4'b0001 || timeout !== 1'b0) $display("FAIL timeout_regrant: got gnt=%b to=%b want 0001/0", gnt, timeout);
        else pass_cnt++;
`else
        for (int k = 0; k < 100; k++) begin
            tick(4'b0001);
            total_cnt++;
            if (gnt !== 4'b0001 || timeout !== 1'b0) $display("FAIL notimeout_hold%0d: got gnt=%b to=%b want 0001/0", k, gnt, timeout);
            else pass_cnt++;
        end
`endif
        tick(4'b0000);
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] exp_gnt;
        for (int n = 0; n < 600; n++) begin
            r = 4'($urandom);
            if (m_busy && $urandom_range(0, 4) != 0) r[m_owner] = 1'b1;
            tick(r);
            exp_gnt = 4'b0000;
            if (m_busy) exp_gnt[m_owner] = 1'b1;
            total_cnt++;
            if (gnt !== exp_gnt || gnt_id !== 2'(m_owner) || busy !== m_busy || timeout !== m_timeout)
                $display("FAIL random%0d: got gnt=%b id=%0d busy=%b to=%b want %b/%0d/%b/%b",
                         n, gnt, gnt_id, busy, timeout, exp_gnt, m_owner, m_busy, m_timeout);
            else pass_cnt++;
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_wrap_no_preempt();
        test_idle();
        test_timeout();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
Four-requester round-robin arbiter that shares one counter/datapath resource between requesters. Its 2-bit priority pointer advances 0→1→2→3→0, the same wrap sequence as the team's 2-bit up counter. Grants are registered, one-hot and held until the owner drops its request. Sits between requester blocks and the shared resource; gnt_id drives the resource's input mux select.

Parameters:
MAX_HOLD, 8, maximum consecutive grant cycles per owner; legal range 2..255; used only when ARB_TIMEOUT_EN is defined.
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req  input  4  request vector; req[i] high = requester i wants the resource
gnt  output  4  one-hot grant, registered; all-zero when no owner
gnt_id  output  2  index of current/last owner, registered
busy  output  1  high while in GRANT state
timeout  output  1  one-cycle pulse on forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (asynchronous, active-high; clk rising edge): state=IDLE, gnt=4'b0000, gnt_id=2'b00, busy=0, timeout=0, ptr=2'b00, hold counter=0. Takes effect immediately, mid-grant included; the grant is lost, no timeout pulse.
- Internal state: 2-bit ptr (highest-priority index); FSM state IDLE/GRANT; hold counter (CNT_W bits, only with ARB_TIMEOUT_EN).
- IDLE:
  - req==0: stay IDLE, outputs unchanged.
  - Otherwise select first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: gnt=onehot(i), gnt_id=i, busy=1, state=GRANT.
  - Latency: req seen at edge N → gnt high after edge N.
- GRANT:
  - req[gnt_id]=1: hold; gnt, gnt_id and ptr unchanged. Other req bits are ignored (no preemption).
  - req[gnt_id]=0: next edge gnt=0, busy=0, ptr=gnt_id+1 (3 wraps to 0), state=IDLE. gnt_id keeps the last owner.
- Handover: at least one idle cycle with gnt=0 between owners. The requester whose grant was released has lowest priority in the following arbitration.
- Fairness: with all four req held continuously and requesters dropping after use, grant order is 0,1,2,3,0,...
- Invariants: gnt is one-hot or zero; gnt!=0 iff busy; gnt[gnt_id]=busy.
- Glitches on non-owner req bits during GRANT have no effect.
- Timeout counter and pulse: see Optional Feature.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - Hold counter clears on entry to GRANT and increments each GRANT cycle.
  - If the owner's req is still high when the count reaches MAX_HOLD-1, the next edge forces release: gnt=0, busy=0, ptr=gnt_id+1, state=IDLE, timeout=1 for exactly one cycle.
  - The owner may re-request and is granted again per round-robin order.
  - If release by req drop and the timeout occur in the same cycle, it is a normal release with timeout=0.
- Undefined: no counter logic, timeout tied to 0, grants held indefinitely.

Test Plan:
- Reset mid-grant: owner 2 active, assert reset asynchronously between edges → gnt=0000, gnt_id=00, busy=0 immediately; after reset, req=0100 → gnt=0100 one edge later.
- Single request: req=0010 after reset → next edge gnt=0010, gnt_id=01, busy=1; drop req → next edge gnt=0000; ptr now 2.
- Rotation: req=1111 held, each owner drops its own bit one cycle after grant and reasserts it after release → gnt sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- Wrap and no preemption: ptr=3, req=1001 → grant 1000; raise req[1] during grant → gnt stays 1000; release → next grant 0001.
- Idle: req=0000 for 10 cycles → gnt=0000, busy=0, gnt_id holds last owner.
- ARB_TIMEOUT_EN, MAX_HOLD=8: req=0001 held → gnt high for exactly 8 cycles, then gnt=0000 with timeout=1 for 1 cycle, then re-granted 0001; without the macro gnt stays 0001 for 100 cycles and timeout remains 0.
